// File: rtl/pinball_pkg.sv
// pinball_pkg: shared solenoid state encoding and PWM constants
package pinball_pkg;
    typedef enum logic [1:0] {IDLE, KICK, HOLD, COOL} sol_state_t;
    localparam int PWM_PERIOD = 16;
endpackage

// File: rtl/coil_pwm.sv
// coil_pwm: 4-bit hold-phase counter with duty compare, pwm is the compare for the upcoming phase
module coil_pwm
    import pinball_pkg::*;
(
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                clear,
    input  logic [$clog2(PWM_PERIOD+1)-1:0]     duty,
    output logic                                pwm
);
    localparam int PW = $clog2(PWM_PERIOD);
    logic [PW-1:0] r_phase;
    logic [PW-1:0] w_phase_n;
    assign w_phase_n = clear ? '0 : r_phase + 1'b1;
    assign pwm = {1'b0, w_phase_n} < duty;
    // phase advances every cycle and restarts at 0 whenever the caller is outside HOLD
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_phase <= '0;
        else
            r_phase <= w_phase_n;
    end
endmodule

// File: rtl/solenoid_driver.sv
// solenoid_driver: fire pulse to timed kick, optional PWM hold (SOLENOID_HOLD_PWM_EN), and cooldown
module solenoid_driver
    import pinball_pkg::*;
#(
    parameter int KICK_CYCLES = 8,
    parameter int COOL_CYCLES = 8,
    parameter int HOLD_DUTY   = 4
)
(
    input  logic clk,
    input  logic rst_n,
    input  logic fire,
    input  logic hold,
    output logic coil,
    output logic busy,
    output logic dropped
);
    localparam int MAXC = (KICK_CYCLES > COOL_CYCLES) ? KICK_CYCLES : COOL_CYCLES;
    localparam int CW = $clog2(MAXC) + 1;
    localparam int DW = $clog2(PWM_PERIOD + 1);
    localparam logic [CW-1:0] KICK_LD = CW'(KICK_CYCLES - 1);
    localparam logic [CW-1:0] COOL_LD = CW'(COOL_CYCLES - 1);
    localparam logic [DW-1:0] DUTY = DW'(HOLD_DUTY);
    sol_state_t    r_state, w_state_n;
    logic [CW-1:0] r_cnt, w_cnt_n;
    logic          r_coil, w_coil_n;
    logic          r_dropped, w_dropped_n;
    logic          w_pwm;
    logic          w_hold_go;
`ifdef SOLENOID_HOLD_PWM_EN
    coil_pwm u_pwm (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (r_state != HOLD),
        .duty  (DUTY),
        .pwm   (w_pwm)
    );
    assign w_hold_go = hold;
`else
    logic w_unused;
    assign w_unused  = ^{hold, DUTY};
    assign w_pwm     = 1'b0;
    assign w_hold_go = 1'b0;
`endif
    assign coil    = r_coil;
    assign busy    = r_state != IDLE;
    assign dropped = r_dropped;
    // next state, shared counter, and next-cycle coil/dropped values
    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt;
        case (r_state)
            IDLE: if (fire) begin
                w_state_n = KICK;
                w_cnt_n   = KICK_LD;
            end
            KICK: if (r_cnt == '0) begin
                if (w_hold_go)
                    w_state_n = HOLD;
                else begin
                    w_state_n = COOL;
                    w_cnt_n   = COOL_LD;
                end
            end else
                w_cnt_n = r_cnt - 1'b1;
            HOLD: if (!w_hold_go) begin
                w_state_n = COOL;
                w_cnt_n   = COOL_LD;
            end
            COOL: if (r_cnt == '0)
                w_state_n = IDLE;
            else
                w_cnt_n = r_cnt - 1'b1;
            default: w_state_n = IDLE;
        endcase
        w_coil_n    = (w_state_n == KICK) || (w_state_n == HOLD && w_pwm);
        w_dropped_n = fire && (r_state != IDLE);
    end
    // all state and outputs are registered so no input reaches a pin combinationally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_coil    <= 1'b0;
            r_dropped <= 1'b0;
        end else begin
            r_state   <= w_state_n;
            r_cnt     <= w_cnt_n;
            r_coil    <= w_coil_n;
            r_dropped <= w_dropped_n;
        end
    end
endmodule

// File: tb/tb_solenoid_driver.sv
// tb_solenoid_driver: directed vector and sequence checks for solenoid_driver
module tb_solenoid_driver;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic fire = 1'b0;
    logic hold = 1'b0;
    logic coil, busy, dropped;
    logic coil0, busy0, dropped0;
    logic coil16, busy16, dropped16;
    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic f;
        logic h;
        logic c;
        logic b;
        logic d;
    } vec_t;
    vec_t tv[19];

    always #5 clk = ~clk;

    solenoid_driver #(.KICK_CYCLES(4), .COOL_CYCLES(3), .HOLD_DUTY(4)) dut (
        .clk(clk), .rst_n(rst_n), .fire(fire), .hold(hold),
        .coil(coil), .busy(busy), .dropped(dropped)
    );
    solenoid_driver #(.KICK_CYCLES(4), .COOL_CYCLES(3), .HOLD_DUTY(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .fire(fire), .hold(hold),
        .coil(coil0), .busy(busy0), .dropped(dropped0)
    );
    solenoid_driver #(.KICK_CYCLES(4), .COOL_CYCLES(3), .HOLD_DUTY(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .fire(fire), .hold(hold),
        .coil(coil16), .busy(busy16), .dropped(dropped16)
    );

    task automatic chk(input string nm, input int cyc, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %b expected %b", nm, cyc, act, exp);
        end
    endtask

    function automatic logic exp_coil(input int c, input int duty);
`ifdef SOLENOID_HOLD_PWM_EN
        if (c >= 11 && c <= 14) return 1'b1;
        if (c >= 15 && c <= 50) return ((c - 15) % 16) < duty;
        return 1'b0;
`else
        return (c >= 11 && c <= 14) && (duty >= 0);
`endif
    endfunction

    function automatic logic exp_busy(input int c);
`ifdef SOLENOID_HOLD_PWM_EN
        return c >= 11 && c <= 53;
`else
        return c >= 11 && c <= 17;
`endif
    endfunction

    initial begin
        tv[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tv[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tv[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tv[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        tv[4]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        tv[5]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        tv[6]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        tv[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tv[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        tv[9]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        tv[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        tv[11] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        tv[12] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        tv[13] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        tv[14] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        tv[15] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tv[16] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tv[17] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tv[18] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

        #1;
        chk("rst_coil", 0, coil, 1'b0);
        chk("rst_busy", 0, busy, 1'b0);
        chk("rst_dropped", 0, dropped, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // single shot, rejected fires mid-kick and on the last cool cycle, refire on the idle cycle
        for (int i = 0; i < 19; i++) begin
            @(posedge clk);
            #1;
            chk("vec_coil", i + 8, coil, tv[i].c);
            chk("vec_busy", i + 8, busy, tv[i].b);
            chk("vec_dropped", i + 8, dropped, tv[i].d);
            fire = tv[i].f;
            hold = tv[i].h;
        end
        fire = 1'b0;
        hold = 1'b0;
        repeat (4) @(posedge clk);

        // hold sequence across three duty settings
        for (int c = 0; c <= 60; c++) begin
            @(posedge clk);
            #1;
            chk("hold_coil", c, coil, exp_coil(c, 4));
            chk("hold_busy", c, busy, exp_busy(c));
            chk("hold_dropped", c, dropped, 1'b0);
            chk("d0_coil", c, coil0, exp_coil(c, 0));
            chk("d0_busy", c, busy0, exp_busy(c));
            chk("d16_coil", c, coil16, exp_coil(c, 16));
            chk("d16_busy", c, busy16, exp_busy(c));
            fire = (c == 10);
            hold = (c >= 10 && c <= 49);
        end
        fire = 1'b0;
        hold = 1'b0;
        repeat (3) @(posedge clk);

        // asynchronous reset mid-kick, then a full fresh kick
        @(posedge clk);
        #1 fire = 1'b1;
        @(posedge clk);
        #1 fire = 1'b0;
        chk("pre_rst_coil", 1, coil, 1'b1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("async_rst_coil", 2, coil, 1'b0);
        chk("async_rst_busy", 2, busy, 1'b0);
        chk("async_rst_dropped", 2, dropped, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rst_hold_coil", 3, coil, 1'b0);
        @(posedge clk);
        #1 fire = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            @(posedge clk);
            #1 fire = 1'b0;
            chk("post_rst_coil", k, coil, k <= 4);
            chk("post_rst_busy", k, busy, k <= 7);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
